fetch_unit: RTL and testbench

Instruction fetch stage sitting directly upstream of `mainmem`. It owns the program counter, drives the memory's address and read/write inputs, captures the combinationally returned word, and hands `{pc, instruction}` pairs to decode through a 2-entry buffer with a valid/ready handshake. It supports PC redirect with buffer flush, and latches a sticky fault on misaligned or out-of-range fetch addresses.

---
 rtl/fetch_unit.sv | 79 +++++++
 tb/tb_fetch_unit.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: PC owner and mainmem read driver feeding a 2-entry {pc,inst} buffer with redirect flush and sticky fault; FETCH_TRACE_EN adds push/fault trace output
module fetch_unit #(
  parameter logic [31:0] STARTING_ADDR   = 32'h01000000,
  parameter logic [31:0] MEM_DEPTH_BYTES = 32'h00100000
) (
  input  logic        clock,
  input  logic        reset,
  output logic [31:0] mem_address,
  output logic        mem_read_write,
  output logic [31:0] mem_data_in,
  input  logic [31:0] mem_data_out,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst,
  output logic [31:0] inst_pc,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        fault,
  output logic [31:0] fault_pc
);
  typedef enum logic {RUN, FAULT} state_t;
  localparam logic [31:0] LAST_ADDR = STARTING_ADDR + MEM_DEPTH_BYTES - 32'd4;
  state_t      state, state_nxt;
  logic [31:0] pc;
  logic [63:0] fifo [2];
  logic        rd_ptr, wr_ptr;
  logic [1:0]  count;
  logic        legal, pop, redir, push, go_fault;
  assign mem_address    = pc;
  assign mem_read_write = 1'b0;
  assign mem_data_in    = 32'h0;
  assign inst_valid     = count != 2'd0;
  assign {inst_pc, inst} = fifo[rd_ptr];
  assign fault          = state == FAULT;
  always_comb begin
    legal     = pc[1:0] == 2'b00 && pc >= STARTING_ADDR && pc <= LAST_ADDR;
    pop       = inst_valid && inst_ready;
    redir     = state == RUN && redirect_valid;
    push      = state == RUN && !redirect_valid && legal && (count != 2'd2 || pop);
    go_fault  = state == RUN && !redirect_valid && !legal;
    state_nxt = go_fault ? FAULT : state;
  end
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= RUN;
      pc       <= STARTING_ADDR;
      fifo[0]  <= 64'h0;
      fifo[1]  <= 64'h0;
      rd_ptr   <= 1'b0;
      wr_ptr   <= 1'b0;
      count    <= 2'd0;
      fault_pc <= 32'h0;
    end else begin
      state <= state_nxt;
      if (redir) begin
        pc     <= redirect_pc;
        rd_ptr <= 1'b0;
        wr_ptr <= 1'b0;
        count  <= 2'd0;
      end else begin
        if (push) begin
          fifo[wr_ptr] <= {pc, mem_data_out};
          wr_ptr       <= ~wr_ptr;
          pc           <= pc + 32'd4;
        end
        if (pop) rd_ptr <= ~rd_ptr;
        count <= count + {1'b0, push} - {1'b0, pop};
      end
      if (go_fault) fault_pc <= pc;
    end
  end
`ifdef FETCH_TRACE_EN
  always_ff @(posedge clock) begin
    if (!reset && push) $display("time=%t, address=%8h, data_out=%8h", $time, pc, mem_data_out);
    if (!reset && go_fault) $display("time=%t, fault_pc=%8h", $time, pc);
  end
`else
`endif
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: randomized and directed checks of fetch_unit against a queue-based reference model
module tb_fetch_unit;
  localparam logic [31:0] START = 32'h01000000;
  localparam logic [31:0] DEPTH = 32'h00100000;
  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic [31:0] mem_address, mem_data_in, mem_data_out, inst, inst_pc, redirect_pc, fault_pc;
  logic        mem_read_write, inst_valid, inst_ready, redirect_valid, fault;
  int          n_cmp = 0;
  int          n_fail = 0;
  logic [63:0] q [$];
  logic [31:0] m_pc, m_fpc;
  logic        m_fault;
  always #5 clock = ~clock;
  function automatic logic [31:0] word(input logic [31:0] a);
    return (a * 32'h9E3779B1) ^ 32'h5A5A1234;
  endfunction
  assign mem_data_out = word(mem_address);
  fetch_unit #(.STARTING_ADDR(START), .MEM_DEPTH_BYTES(DEPTH)) dut (
    .clock(clock), .reset(reset), .mem_address(mem_address), .mem_read_write(mem_read_write),
    .mem_data_in(mem_data_in), .mem_data_out(mem_data_out), .inst_valid(inst_valid),
    .inst_ready(inst_ready), .inst(inst), .inst_pc(inst_pc), .redirect_valid(redirect_valid),
    .redirect_pc(redirect_pc), .fault(fault), .fault_pc(fault_pc)
  );
  function automatic bit legal(input logic [31:0] a);
    return a[1:0] == 2'b00 && a >= START && a <= START + DEPTH - 32'd4;
  endfunction
  task automatic model_tick();
    bit pop, space;
    if (reset) begin
      q = {};
      m_pc = START;
      m_fault = 1'b0;
      m_fpc = 32'h0;
    end else begin
      pop = q.size() != 0 && inst_ready;
      space = q.size() < 2 || pop;
      if (!m_fault && redirect_valid) begin
        q = {};
        m_pc = redirect_pc;
      end else begin
        if (pop) void'(q.pop_front());
        if (!m_fault && !legal(m_pc)) begin
          m_fault = 1'b1;
          m_fpc = m_pc;
        end else if (!m_fault && space) begin
          q.push_back({m_pc, word(m_pc)});
          m_pc = m_pc + 32'd4;
        end
      end
    end
  endtask
  task automatic cycle();
    model_tick();
    @(posedge clock);
    #1;
  endtask
  function automatic logic [162:0] dut_view();
    return {inst_valid, inst_valid ? inst : 32'h0, inst_valid ? inst_pc : 32'h0, mem_address,
            fault, fault_pc, mem_read_write, mem_data_in};
  endfunction
  function automatic logic [162:0] model_view();
    logic [63:0] hd;
    hd = q.size() != 0 ? q[0] : 64'h0;
    return {q.size() != 0, hd[31:0], hd[63:32], m_pc, m_fault, m_fpc, 1'b0, 32'h0};
  endfunction
  task automatic do_reset();
    reset = 1'b1;
    inst_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;
    cycle();
    reset = 1'b0;
  endtask
  task automatic test_reset();
    do_reset();
    reset = 1'b1;
    cycle();
    n_cmp++;
    if ({inst_valid, inst, inst_pc, mem_address, fault, fault_pc, mem_read_write, mem_data_in} !==
        {1'b0, 32'h0, 32'h0, START, 1'b0, 32'h0, 1'b0, 32'h0}) begin
      n_fail++;
      $display("FAIL reset_state: got v=%b inst=%h pc=%h addr=%h f=%b fpc=%h rw=%b din=%h, want all zero with addr=%h",
               inst_valid, inst, inst_pc, mem_address, fault, fault_pc, mem_read_write, mem_data_in, START);
    end
    reset = 1'b0;
  endtask
  task automatic test_stream();
    logic [31:0] a;
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 8; i++) begin
      cycle();
      a = START + 32'(4 * i);
      n_cmp++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, a, word(a)}) begin
        n_fail++;
        $display("FAIL stream[%0d]: got v=%b pc=%h inst=%h, want v=1 pc=%h inst=%h", i, inst_valid, inst_pc, inst, a, word(a));
      end
      n_cmp++;
      if (dut_view() !== model_view()) begin
        n_fail++;
        $display("FAIL stream_model[%0d]: got %h want %h", i, dut_view(), model_view());
      end
    end
  endtask
  task automatic test_backpressure();
    logic [31:0] a;
    do_reset();
    for (int i = 0; i < 5; i++) cycle();
    n_cmp++;
    if ({inst_valid, inst_pc, mem_address} !== {1'b1, START, START + 32'd8}) begin
      n_fail++;
      $display("FAIL backpressure_hold: got v=%b pc=%h addr=%h, want v=1 pc=%h addr=%h",
               inst_valid, inst_pc, mem_address, START, START + 32'd8);
    end
    inst_ready = 1'b1;
    for (int i = 1; i <= 3; i++) begin
      cycle();
      a = START + 32'(4 * i);
      n_cmp++;
      if ({inst_valid, inst_pc, inst} !== {1'b1, a, word(a)}) begin
        n_fail++;
        $display("FAIL backpressure_release[%0d]: got v=%b pc=%h inst=%h, want pc=%h inst=%h", i, inst_valid, inst_pc, inst, a, word(a));
      end
    end
    n_cmp++;
    if (dut_view() !== model_view()) begin
      n_fail++;
      $display("FAIL backpressure_model: got %h want %h", dut_view(), model_view());
    end
  endtask
  task automatic test_redirect();
    do_reset();
    inst_ready = 1'b1;
    for (int i = 0; i < 3; i++) cycle();
    n_cmp++;
    if (inst_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL redirect_pop_valid: got v=%b want 1", inst_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = 32'h01000100;
    cycle();
    redirect_valid = 1'b0;
    n_cmp++;
    if ({inst_valid, mem_address} !== {1'b0, 32'h01000100}) begin
      n_fail++;
      $display("FAIL redirect_gap: got v=%b addr=%h, want v=0 addr=01000100", inst_valid, mem_address);
    end
    cycle();
    n_cmp++;
    if ({inst_valid, inst_pc, inst} !== {1'b1, 32'h01000100, word(32'h01000100)}) begin
      n_fail++;
      $display("FAIL redirect_first: got v=%b pc=%h inst=%h, want pc=01000100", inst_valid, inst_pc, inst);
    end
  endtask
  task automatic test_misalign();
    do_reset();
    inst_ready = 1'b1;
    cycle();
    redirect_valid = 1'b1;
    redirect_pc = 32'h01000102;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    n_cmp++;
    if ({fault, fault_pc, inst_valid} !== {1'b1, 32'h01000102, 1'b0}) begin
      n_fail++;
      $display("FAIL misalign_fault: got f=%b fpc=%h v=%b, want f=1 fpc=01000102 v=0", fault, fault_pc, inst_valid);
    end
    redirect_valid = 1'b1;
    redirect_pc = START;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    n_cmp++;
    if ({fault, mem_address, inst_valid, fault_pc} !== {1'b1, 32'h01000102, 1'b0, 32'h01000102}) begin
      n_fail++;
      $display("FAIL misalign_ignore_redirect: got f=%b addr=%h v=%b fpc=%h, want f=1 addr=01000102 v=0", fault, mem_address, inst_valid, fault_pc);
    end
  endtask
  task automatic test_end_window();
    do_reset();
    inst_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_pc = 32'h010FFFFC;
    cycle();
    redirect_valid = 1'b0;
    cycle();
    n_cmp++;
    if ({inst_valid, inst_pc, inst, fault} !== {1'b1, 32'h010FFFFC, word(32'h010FFFFC), 1'b0}) begin
      n_fail++;
      $display("FAIL end_window_last: got v=%b pc=%h inst=%h f=%b, want pc=010FFFFC f=0", inst_valid, inst_pc, inst, fault);
    end
    cycle();
    n_cmp++;
    if ({fault, fault_pc, inst_valid} !== {1'b1, 32'h01100000, 1'b0}) begin
      n_fail++;
      $display("FAIL end_window_fault: got f=%b fpc=%h v=%b, want f=1 fpc=01100000 v=0", fault, fault_pc, inst_valid);
    end
  endtask
  task automatic test_reset_mid();
    do_reset();
    for (int i = 0; i < 3; i++) cycle();
    reset = 1'b1;
    cycle();
    reset = 1'b0;
    n_cmp++;
    if ({inst_valid, mem_address} !== {1'b0, START}) begin
      n_fail++;
      $display("FAIL reset_mid: got v=%b addr=%h, want v=0 addr=%h", inst_valid, mem_address, START);
    end
    inst_ready = 1'b1;
    cycle();
    n_cmp++;
    if ({inst_valid, inst_pc} !== {1'b1, START}) begin
      n_fail++;
      $display("FAIL reset_mid_restart: got v=%b pc=%h, want v=1 pc=%h", inst_valid, inst_pc, START);
    end
  endtask
  task automatic test_random();
    int bad = 0;
    do_reset();
    for (int i = 0; i < 600; i++) begin
      reset = $urandom_range(0, 39) == 0;
      inst_ready = $urandom_range(0, 2) != 0;
      redirect_valid = $urandom_range(0, 7) == 0;
      case ($urandom_range(0, 9))
        0: redirect_pc = START + 32'($urandom_range(0, 63) << 2) + 32'd2;
        1: redirect_pc = START + DEPTH - 32'($urandom_range(1, 3) << 2);
        2: redirect_pc = START - 32'd4;
        default: redirect_pc = START + 32'($urandom_range(0, 255) << 2);
      endcase
      cycle();
      n_cmp++;
      if (dut_view() !== model_view()) begin
        n_fail++;
        bad++;
        if (bad <= 5) $display("FAIL random[%0d]: got %h want %h", i, dut_view(), model_view());
      end
    end
    reset = 1'b0;
    redirect_valid = 1'b0;
  endtask
  initial begin
    test_reset();
    test_stream();
    test_backpressure();
    test_redirect();
    test_misalign();
    test_end_window();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
